// File: rtl/plic_gateway_bank.sv
// rtl/plic_gateway_bank.sv - bank of PLIC interrupt gateways, one FSM plus edge counter per source
module plic_gateway_bank #(
  parameter int unsigned NUM_GATEWAYS      = 1,
  parameter int unsigned MAX_PENDING_COUNT = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_GATEWAYS-1:0] irq_sources_i,
  input  logic [NUM_GATEWAYS-1:0] edge_sensitive_i,
  input  logic [NUM_GATEWAYS-1:0] claim_i,
  input  logic [NUM_GATEWAYS-1:0] complete_i,
  output logic [NUM_GATEWAYS-1:0] pending_o,
  output logic [NUM_GATEWAYS-1:0] in_service_o
);

  localparam int unsigned CW = $clog2(MAX_PENDING_COUNT + 1);
  localparam logic [CW:0] MAX_C = (CW + 1)'(MAX_PENDING_COUNT);

  // Encoding chosen so each output is a single state flop bit.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    CLAIMED = 2'b10
  } state_e;

  for (genvar g = 0; g < NUM_GATEWAYS; g++) begin : g_gw
    state_e        state_q, state_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   sum;
    logic          edge_w;
    logic          take;

    assign edge_w = irq_sources_i[g] & ~prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        prev_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        prev_q  <= irq_sources_i[g];
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      take    = 1'b0;
      case (state_q)
        IDLE: begin
          if (edge_sensitive_i[g]) begin
            if ((cnt_q != '0) || edge_w) begin
              state_d = PENDING;
              take    = 1'b1;
            end
          end else if (irq_sources_i[g]) begin
            state_d = PENDING;
          end
        end
        PENDING: if (claim_i[g])    state_d = CLAIMED;
        CLAIMED: if (complete_i[g]) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // An edge coinciding with a take nets out; saturation drops only surplus edges.
    always_comb begin
      sum = {1'b0, cnt_q} + (CW + 1)'(edge_w);
      if (take) sum = sum - (CW + 1)'(1);
      if (sum > MAX_C) sum = MAX_C;
      cnt_d = edge_sensitive_i[g] ? sum[CW-1:0] : '0;
    end

    assign pending_o[g]    = state_q[0];
    assign in_service_o[g] = state_q[1];
  end

endmodule

// File: tb/tb_plic_gateway_bank.sv
// tb/tb_plic_gateway_bank.sv - directed self-checking bench for plic_gateway_bank
module tb_plic_gateway_bank;

  logic       clk;
  logic       rst_n;
  logic [1:0] src, es, claim, comp;
  logic [1:0] pend, insvc;
  int         checks = 0;
  int         errors = 0;

  plic_gateway_bank #(.NUM_GATEWAYS(2), .MAX_PENDING_COUNT(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .irq_sources_i   (src),
    .edge_sensitive_i(es),
    .claim_i         (claim),
    .complete_i      (comp),
    .pending_o       (pend),
    .in_service_o    (insvc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input int g);
    claim[g] = 1'b1;
    step();
    claim[g] = 1'b0;
    comp[g]  = 1'b1;
    step();
    comp[g]  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src = 2'b01; es = 2'b00; claim = 2'b00; comp = 2'b00;
    step(); step();
    checks++; if (pend !== 2'b00) begin errors++; $display("FAIL reset_pend got %b want 00", pend); end
    checks++; if (insvc !== 2'b00) begin errors++; $display("FAIL reset_insvc got %b want 00", insvc); end
    rst_n = 1'b1;
    step();
    checks++; if (pend !== 2'b01) begin errors++; $display("FAIL level_req got %b want 01", pend); end
    claim[0] = 1'b1; step(); claim[0] = 1'b0;
    checks++; if (pend !== 2'b00 || insvc !== 2'b01) begin errors++; $display("FAIL level_claim got p=%b s=%b want p=00 s=01", pend, insvc); end
    comp[0] = 1'b1; step(); comp[0] = 1'b0;
    checks++; if (pend !== 2'b00 || insvc !== 2'b00) begin errors++; $display("FAIL idle_gap got p=%b s=%b want p=00 s=00", pend, insvc); end
    step();
    checks++; if (pend !== 2'b01) begin errors++; $display("FAIL re_request got %b want 01", pend); end
    src = 2'b00;
    serve(0);
    step();
  endtask

  task automatic test_level_drop();
    src[0] = 1'b1; step(); src[0] = 1'b0;
    checks++; if (pend[0] !== 1'b1) begin errors++; $display("FAIL drop_req got %b want 1", pend[0]); end
    step(); step(); step();
    checks++; if (pend[0] !== 1'b1) begin errors++; $display("FAIL drop_hold got %b want 1", pend[0]); end
    serve(0);
    step(); step();
    checks++; if (pend[0] !== 1'b0 || insvc[0] !== 1'b0) begin errors++; $display("FAIL drop_idle got p=%b s=%b want 0 0", pend[0], insvc[0]); end
  endtask

  task automatic test_edge_count();
    int rounds = 0;
    es[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src[0] = 1'b1; step(); src[0] = 1'b0; step();
    end
    checks++; if (pend[0] !== 1'b1) begin errors++; $display("FAIL edge_req got %b want 1", pend[0]); end
    for (int i = 0; i < 12; i++) begin
      step();
      if (pend[0] === 1'b1) begin rounds++; serve(0); end
    end
    checks++; if (rounds !== 3) begin errors++; $display("FAIL edge_rounds got %0d want 3", rounds); end
  endtask

  task automatic test_saturation();
    int rounds = 0;
    src[0] = 1'b1; step(); src[0] = 1'b0; step();
    claim[0] = 1'b1; step(); claim[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      src[0] = 1'b1; step(); src[0] = 1'b0; step();
    end
    checks++; if (insvc[0] !== 1'b1 || pend[0] !== 1'b0) begin errors++; $display("FAIL sat_claimed got p=%b s=%b want 0 1", pend[0], insvc[0]); end
    comp[0] = 1'b1; step(); comp[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pend[0] === 1'b1) begin rounds++; serve(0); end
    end
    checks++; if (rounds !== 4) begin errors++; $display("FAIL sat_rounds got %0d want 4", rounds); end
    es[0] = 1'b0;
  endtask

  task automatic test_stray();
    src[0] = 1'b1; step(); src[0] = 1'b0;
    comp[0] = 1'b1; step(); comp[0] = 1'b0;
    checks++; if (pend[0] !== 1'b1 || insvc[0] !== 1'b0) begin errors++; $display("FAIL stray_comp got p=%b s=%b want 1 0", pend[0], insvc[0]); end
    claim[0] = 1'b1; step();
    step(); claim[0] = 1'b0;
    checks++; if (pend[0] !== 1'b0 || insvc[0] !== 1'b1) begin errors++; $display("FAIL stray_claim got p=%b s=%b want 0 1", pend[0], insvc[0]); end
    comp[0] = 1'b1; step(); comp[0] = 1'b0;
    src[0] = 1'b1; step(); src[0] = 1'b0;
    claim[0] = 1'b1; comp[0] = 1'b1; step(); claim[0] = 1'b0; comp[0] = 1'b0;
    checks++; if (pend[0] !== 1'b0 || insvc[0] !== 1'b1) begin errors++; $display("FAIL simul_pulse got p=%b s=%b want 0 1", pend[0], insvc[0]); end
    comp[0] = 1'b1; step(); comp[0] = 1'b0;
    step();
  endtask

  task automatic test_indep_reset();
    es = 2'b10;
    src = 2'b11; step(); src = 2'b00; step();
    src[1] = 1'b1; step(); src[1] = 1'b0; step();
    src[1] = 1'b1; step(); src[1] = 1'b0;
    claim[0] = 1'b1; step(); claim[0] = 1'b0;
    checks++; if (pend !== 2'b10 || insvc !== 2'b01) begin errors++; $display("FAIL indep_pre got p=%b s=%b want 10 01", pend, insvc); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (pend !== 2'b00 || insvc !== 2'b00) begin errors++; $display("FAIL async_reset got p=%b s=%b want 00 00", pend, insvc); end
    step(); rst_n = 1'b1;
    step(); step(); step();
    checks++; if (pend !== 2'b00) begin errors++; $display("FAIL cnt_cleared got %b want 00", pend); end
    src[1] = 1'b1; step(); src[1] = 1'b0;
    checks++; if (pend !== 2'b10 || insvc !== 2'b00) begin errors++; $display("FAIL post_reset_g1 got p=%b s=%b want 10 00", pend, insvc); end
    claim[1] = 1'b1; step(); claim[1] = 1'b0;
    checks++; if (pend !== 2'b00 || insvc !== 2'b10) begin errors++; $display("FAIL post_claim_g1 got p=%b s=%b want 00 10", pend, insvc); end
  endtask

  initial begin
    test_reset();
    test_level_drop();
    test_edge_count();
    test_saturation();
    test_stray();
    test_indep_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
